// File: rtl/tm_pkg.sv
// Shared types for the Tsetlin machine training path: feedback encoding, control states and
// Galois LFSR tap masks.
package tm_pkg;

  typedef enum logic [1:0] {
    FB_NONE    = 2'b00,
    FB_TYPE_I  = 2'b01,
    FB_TYPE_II = 2'b10
  } fb_type_t;

  typedef enum logic [1:0] {
    StIdle,
    StSum,
    StIssue,
    StDone
  } fb_state_e;

  // Right-shifting Galois masks (bit k-1 set for tap k) of maximal-length polynomials.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      3:       return 64'h6;
      4:       return 64'hC;
      5:       return 64'h14;
      6:       return 64'h30;
      7:       return 64'h60;
      8:       return 64'hB8;
      16:      return 64'hB400;
      24:      return 64'hE10000;
      32:      return 64'h8020_0003;
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/tm_lfsr.sv
// Galois LFSR that steps only when enable is high; state starts from SEED on reset.
module tm_lfsr
  import tm_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] Taps = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (enable) begin
      state_d = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? Taps : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/tm_clause_feedback.sv
// Recomputes the clamped clause vote for a captured sample and streams per-clause feedback.
// Define TM_FEEDBACK_SKIP_EN to suppress beats for unselected clauses.
module tm_clause_feedback
  import tm_pkg::*;
#(
  parameter int unsigned       N_CLAUSES = 2,
  parameter int unsigned       T         = 2,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_CLAUSES-1:0]           pos_clause,
  input  logic [N_CLAUSES-1:0]           neg_clause,
  input  logic                           target,
  output logic                           decision,
  output logic                           fb_valid,
  input  logic                           fb_ready,
  output logic [$clog2(2*N_CLAUSES)-1:0] fb_idx,
  output logic [1:0]                     fb_type,
  output logic                           done
);

  localparam int unsigned NT    = 2 * N_CLAUSES;
  localparam int unsigned IW    = $clog2(NT);
  localparam int unsigned VW    = $clog2(N_CLAUSES + 1) + 1;
  localparam int unsigned PW    = $clog2(2 * T + 1);
  localparam int unsigned PRODW = LFSR_W + PW + 1;

  localparam logic [IW-1:0]    LastIdx = IW'(NT - 1);
  localparam logic [IW-1:0]    NegBase = IW'(N_CLAUSES);
  localparam logic [PRODW-1:0] TwoT    = PRODW'(2 * T);

  fb_state_e            state_q, state_d;
  logic [N_CLAUSES-1:0] pos_q, pos_d, neg_q, neg_d;
  logic                 y_q, y_d, decision_q, decision_d;
  logic [PW-1:0]        p_q, p_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [LFSR_W-1:0]    lfsr;
  logic                 issue, sel, is_neg, adv;
  logic [VW-1:0]        pc_pos, pc_neg;
  logic signed [VW-1:0] vote;
  int signed            vote_c, p_int;
  fb_type_t             fb_type_v;

  tm_lfsr #(
    .LFSR_W(LFSR_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .enable(issue & adv),
    .state (lfsr)
  );

  // Vote sum and selection probability numerator p (out of 2T).
  always_comb begin
    pc_pos = '0;
    pc_neg = '0;
    for (int i = 0; i < int'(N_CLAUSES); i++) begin
      pc_pos = pc_pos + VW'(pos_q[i]);
      pc_neg = pc_neg + VW'(neg_q[i]);
    end
    vote   = $signed(pc_pos - pc_neg);
    vote_c = int'(vote);
    if (vote_c > int'(T)) begin
      vote_c = int'(T);
    end else if (vote_c < -int'(T)) begin
      vote_c = -int'(T);
    end
    p_int = y_q ? int'(T) - vote_c : int'(T) + vote_c;
  end

  assign issue  = (state_q == StIssue);
  assign sel    = (PRODW'(lfsr) * TwoT) < (PRODW'(p_q) << LFSR_W);
  assign is_neg = (idx_q >= NegBase);

`ifdef TM_FEEDBACK_SKIP_EN
  assign adv      = ~sel | fb_ready;
  assign fb_valid = issue & sel;
`else
  assign adv      = fb_ready;
  assign fb_valid = issue;
`endif

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    neg_d      = neg_q;
    y_d        = y_q;
    decision_d = decision_q;
    p_d        = p_q;
    idx_d      = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pos_d   = pos_clause;
          neg_d   = neg_clause;
          y_d     = target;
          state_d = StSum;
        end
      end
      StSum: begin
        decision_d = ~vote[VW-1];
        p_d        = PW'(p_int);
        idx_d      = '0;
        state_d    = StIssue;
      end
      StIssue: begin
        if (adv) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      neg_q      <= '0;
      y_q        <= 1'b0;
      decision_q <= 1'b0;
      p_q        <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      y_q        <= y_d;
      decision_q <= decision_d;
      p_q        <= p_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    fb_type_v = FB_NONE;
    if (issue && sel) begin
      fb_type_v = (y_q ^ is_neg) ? FB_TYPE_I : FB_TYPE_II;
    end
  end

  assign fb_type  = fb_type_v;
  assign fb_idx   = idx_q;
  assign in_ready = (state_q == StIdle);
  assign done     = (state_q == StDone);
  assign decision = decision_q;

endmodule

// File: tb/tb_tm_clause_feedback.sv
// Directed vector bench for tm_clause_feedback (N=2 and N=4 instances, T=2, 16-bit LFSR).
module tb_tm_clause_feedback;

  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       fb_ready = 1'b1, target = 1'b0;
  logic       in_valid2 = 1'b0, in_valid4 = 1'b0;
  logic [1:0] pos2 = '0, neg2 = '0;
  logic [3:0] pos4 = '0, neg4 = '0;

  logic       in_ready2, decision2, fb_valid2, done2;
  logic [1:0] fb_idx2, fb_type2;
  logic       in_ready4, decision4, fb_valid4, done4;
  logic [2:0] fb_idx4;
  logic [1:0] fb_type4;

  tm_clause_feedback #(.N_CLAUSES(2), .T(2), .LFSR_W(16), .LFSR_SEED(Seed)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .pos_clause(pos2), .neg_clause(neg2), .target(target), .decision(decision2),
    .fb_valid(fb_valid2), .fb_ready(fb_ready), .fb_idx(fb_idx2), .fb_type(fb_type2),
    .done(done2)
  );

  tm_clause_feedback #(.N_CLAUSES(4), .T(2), .LFSR_W(16), .LFSR_SEED(Seed)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .pos_clause(pos4), .neg_clause(neg4), .target(target), .decision(decision4),
    .fb_valid(fb_valid4), .fb_ready(fb_ready), .fb_idx(fb_idx4), .fb_type(fb_type4),
    .done(done4)
  );

  logic       use4 = 1'b0;
  logic       c_in_ready, c_decision, c_fb_valid, c_done;
  logic [2:0] c_idx;
  logic [1:0] c_type;
  assign c_in_ready = use4 ? in_ready4 : in_ready2;
  assign c_decision = use4 ? decision4 : decision2;
  assign c_fb_valid = use4 ? fb_valid4 : fb_valid2;
  assign c_done     = use4 ? done4 : done2;
  assign c_idx      = use4 ? fb_idx4 : {1'b0, fb_idx2};
  assign c_type     = use4 ? fb_type4 : fb_type2;

  typedef struct {
    bit       use4;
    logic [3:0] pos;
    logic [3:0] neg;
    logic     y;
    logic     dec;
    int       p;
    bit       stall;
    bit       rst_before;
    bit       cmp_prev;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  logic [15:0] m_lfsr[2];
  int exp_idx[$], exp_type[$], got_idx[$], got_type[$], prev_idx[$], prev_type[$];

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Selected when lfsr*2T < p*2^16, with 2T = 4.
  function automatic bit m_sel(input logic [15:0] l, input int p);
    longint lhs, rhs;
    lhs = longint'(l) * 4;
    rhs = longint'(p) * 65536;
    return lhs < rhs;
  endfunction

  task automatic build_exp(input int n, input int p, input logic y, input bit w4);
    logic [15:0] l;
    bit s;
    int t;
    l = m_lfsr[w4];
    exp_idx.delete();
    exp_type.delete();
    for (int i = 0; i < 2 * n; i++) begin
      s = m_sel(l, p);
      t = s ? ((y ^ (i >= n)) ? 1 : 2) : 0;
`ifdef TM_FEEDBACK_SKIP_EN
      if (s) begin
        exp_idx.push_back(i);
        exp_type.push_back(t);
      end
`else
      exp_idx.push_back(i);
      exp_type.push_back(t);
`endif
      l = m_step(l);
    end
    m_lfsr[w4] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_lfsr[0] = Seed;
    m_lfsr[1] = Seed;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_sample(input vec_t v, input string tag);
    int n, first, done_k, nb;
    bit hold, fin;
    logic [2:0] h_idx;
    logic [1:0] h_type;
    n = v.use4 ? 4 : 2;
    build_exp(n, v.p, v.y, v.use4);
    got_idx.delete();
    got_type.delete();
    @(negedge clk);
    use4   = v.use4;
    target = v.y;
    pos2 = v.pos[1:0]; neg2 = v.neg[1:0]; pos4 = v.pos; neg4 = v.neg;
    #1 chk({tag, "_in_ready"}, c_in_ready, 1);
    if (v.use4) in_valid4 = 1'b1; else in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    in_valid4 = 1'b0;
    first = -1; done_k = -1; hold = 0; fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      if (hold) begin
        chk({tag, "_stall_valid"}, c_fb_valid, 1);
        chk({tag, "_stall_idx"}, c_idx, h_idx);
        chk({tag, "_stall_type"}, c_type, h_type);
        hold = 0;
      end
      if (done_k >= 0) begin
        chk({tag, "_done_width"}, c_done, 0);
        chk({tag, "_ready_back"}, c_in_ready, 1);
        fin = 1;
      end else begin
        fb_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (c_fb_valid) begin
          if (first < 0) first = k;
          if (fb_ready) begin
            got_idx.push_back(int'(c_idx));
            got_type.push_back(int'(c_type));
          end else begin
            hold = 1; h_idx = c_idx; h_type = c_type;
          end
        end
        if (c_done) done_k = k;
      end
    end
    fb_ready = 1'b1;
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_decision"}, c_decision, v.dec);
    chk({tag, "_nbeats"}, got_idx.size(), exp_idx.size());
    nb = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_idx[i]);
      chk($sformatf("%s_type%0d", tag, i), got_type[i], exp_type[i]);
    end
`ifndef TM_FEEDBACK_SKIP_EN
    if (!v.stall) begin
      chk({tag, "_first_beat"}, first, 1);
      chk({tag, "_done_cycle"}, done_k, 2 * n + 1);
    end
`endif
    if (v.cmp_prev) begin
      chk({tag, "_replay_n"}, got_idx.size(), prev_idx.size());
      for (int i = 0; i < nb && i < prev_idx.size(); i++) begin
        chk($sformatf("%s_replay_type%0d", tag, i), got_type[i], prev_type[i]);
      end
    end
    prev_idx  = got_idx;
    prev_type = got_type;
  endtask

  vec_t vecs[9];
  vec_t rv;
  bit found;

  initial begin
    vecs[0] = '{1'b0, 4'b0011, 4'b0000, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'b0000, 4'b0011, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'b0001, 4'b0011, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0};

    m_lfsr[0] = Seed;
    m_lfsr[1] = Seed;
    #2;
    chk("rst_in_ready", in_ready2, 1);
    chk("rst_decision", decision2, 0);
    chk("rst_fb_valid", fb_valid2, 0);
    chk("rst_fb_idx", fb_idx2, 0);
    chk("rst_fb_type", fb_type2, 0);
    chk("rst_done", done2, 0);
    chk("rst_in_ready4", in_ready4, 1);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_sample(vecs[i], $sformatf("v%0d", i));
    end

    // Abort mid-stream, then confirm the next sample replays from the seed.
    do_reset();
    use4 = 1'b0; pos2 = 2'b01; neg2 = 2'b01; target = 1'b1; fb_ready = 1'b0;
    @(negedge clk);
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (fb_valid2 && fb_idx2 >= 2'd1) begin
        found = 1;
        fb_ready = 1'b0;
      end else begin
        fb_ready = 1'b1;
      end
    end
    chk("abort_reached_beat", found, 1);
    chk("abort_decision_pre", decision2, 1);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready2, 1);
    chk("abort_decision", decision2, 0);
    chk("abort_fb_valid", fb_valid2, 0);
    chk("abort_fb_idx", fb_idx2, 0);
    chk("abort_fb_type", fb_type2, 0);
    chk("abort_done", done2, 0);
    m_lfsr[0] = Seed;
    m_lfsr[1] = Seed;
    @(negedge clk);
    rst = 1'b0;
    fb_ready = 1'b1;
    rv = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    run_sample(rv, "replay");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
